// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares the single combinational read port of a ROM between two requesters:
// port 0 (instruction fetch) and port 1 (data load). Requests use a
// valid/ready handshake, and arbitration is round-robin between the two
// ports. Each port owns one registered response slot, written at the clock
// edge that ends the cycle in which its request fired. Addresses at or above
// ROM_DEPTH are not read: the slot records err=1 and data=0.
//
// Parameters
//   WORDSIZE   ROM word width and response data width
//   ROM_DEPTH  number of valid ROM words (addresses >= ROM_DEPTH are errors)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low (0 = reset asserted)
//   reqN_valid  port N request valid
//   reqN_addr   port N word address (stable while valid and not ready)
//   reqN_ready  port N request accepted this cycle (combinational)
//   rspN_valid  port N response slot holds a response
//   rspN_data   port N read data (0 for an out-of-range address)
//   rspN_err    port N address was out of range
//   rspN_ready  port N consumer accepts the response
//   rom_addr    address driven to the ROM read port (0 when idle)
//   rom_data    combinational ROM output for rom_addr
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int WORDSIZE  = 32,
    parameter int ROM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_valid,
    input  logic [31:0]         req0_addr,
    output logic                req0_ready,
    output logic                rsp0_valid,
    output logic [WORDSIZE-1:0] rsp0_data,
    output logic                rsp0_err,
    input  logic                rsp0_ready,

    input  logic                req1_valid,
    input  logic [31:0]         req1_addr,
    output logic                req1_ready,
    output logic                rsp1_valid,
    output logic [WORDSIZE-1:0] rsp1_data,
    output logic                rsp1_err,
    input  logic                rsp1_ready,

    output logic [31:0]         rom_addr,
    input  logic [WORDSIZE-1:0] rom_data
);

    // Address bound as an unsigned 32-bit value so the compare is unsigned.
    localparam logic [31:0] DEPTH_LIMIT = 32'(ROM_DEPTH);

    // Round-robin pointer: which port wins when both are eligible.
    typedef enum logic {
        PREFER_P0 = 1'b0,
        PREFER_P1 = 1'b1
    } rr_state_t;

    rr_state_t rr_ptr;
    rr_state_t rr_ptr_next;

    logic                elig0;
    logic                elig1;
    logic                grant0;
    logic                grant1;
    logic                rom_err;
    logic [WORDSIZE-1:0] rom_word;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        return (addr >= DEPTH_LIMIT);
    endfunction

    // Out-of-range reads return zero rather than whatever the ROM drives.
    function automatic logic [WORDSIZE-1:0] masked_word(
        input logic [31:0]         addr,
        input logic [WORDSIZE-1:0] word
    );
        return addr_out_of_range(addr) ? '0 : word;
    endfunction

    // -------------------------------------------------------------------------
    // Eligibility
    // A port may be granted when it has a request and its response slot is
    // empty or is being drained this very cycle. Gating with reset keeps every
    // ready low (and rom_addr at 0) while reset is asserted.
    // -------------------------------------------------------------------------
    always_comb begin
        elig0 = reset & req0_valid & (~rsp0_valid | rsp0_ready);
        elig1 = reset & req1_valid & (~rsp1_valid | rsp1_ready);
    end

    // -------------------------------------------------------------------------
    // Round-robin state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= PREFER_P0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Grant and next pointer
    // A lone eligible port always wins; on contention the pointer decides.
    // Every fire hands preference to the other port, which makes two
    // continuously contending requesters alternate strictly.
    // -------------------------------------------------------------------------
    always_comb begin
        grant0      = 1'b0;
        grant1      = 1'b0;
        rr_ptr_next = rr_ptr;

        case (rr_ptr)
            PREFER_P0: begin
                grant0 = elig0;
                grant1 = elig1 & ~elig0;
            end
            PREFER_P1: begin
                grant1 = elig1;
                grant0 = elig0 & ~elig1;
            end
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase

        if (grant0) begin
            rr_ptr_next = PREFER_P1;
        end else if (grant1) begin
            rr_ptr_next = PREFER_P0;
        end
    end

    // -------------------------------------------------------------------------
    // Request side outputs and ROM address mux
    // rom_data never feeds back into any ready, so the only ready paths are
    // from the request valids and the response readys.
    // -------------------------------------------------------------------------
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;

        if (grant0) begin
            rom_addr = req0_addr;
        end else if (grant1) begin
            rom_addr = req1_addr;
        end else begin
            rom_addr = '0;
        end

        rom_err  = addr_out_of_range(rom_addr);
        rom_word = masked_word(rom_addr, rom_data);
    end

    // -------------------------------------------------------------------------
    // Port 0 response slot
    // A fire loads the slot (overwriting a response retired in the same
    // cycle); a retire without a fire only clears valid, so data and err keep
    // their last values.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp0_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp0_data  <= '0;
        end else if (grant0) begin
            rsp0_valid <= 1'b1;
            rsp0_err   <= rom_err;
            rsp0_data  <= rom_word;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Port 1 response slot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp1_valid <= 1'b0;
            rsp1_err   <= 1'b0;
            rsp1_data  <= '0;
        end else if (grant1) begin
            rsp1_valid <= 1'b1;
            rsp1_err   <= rom_err;
            rsp1_data  <= rom_word;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single combinational read port of the ROM between two requesters: port 0 (instruction fetch) and port 1 (data load).
- Round-robin arbitration, valid/ready handshakes on request and response, one registered response slot per port.
- Out-of-range addresses are flagged, not forwarded as data.
- Sits between the core's fetch/load units and the ROM instance.

Parameters:
- WORDSIZE, 32: ROM word width and response data width.
- ROM_DEPTH, 256: number of valid ROM words; addresses >= ROM_DEPTH are out of range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req0_valid  in  1  port 0 request valid.
- req0_addr  in  32  port 0 word address; held stable while req0_valid=1 and req0_ready=0.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response valid.
- rsp0_data  out  WORDSIZE  port 0 read data.
- rsp0_err  out  1  port 0 address was out of range.
- rsp0_ready  in  1  port 0 consumer accepts the response.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_err, rsp1_ready: identical for port 1.
- rom_addr  out  32  address driven to the ROM read port.
- rom_data  in  WORDSIZE  combinational ROM output for rom_addr.

Behaviour:
- Reset (reset=0, asynchronous): all rsp*_valid, rsp*_data and rsp*_err = 0; rr_ptr = 0. Combinational outputs follow: req*_ready = 0 and rom_addr = 0 while reset is asserted.
- Reset mid-operation: pending responses are dropped, and no handshake completes while reset=0. After release, arbitration restarts with port 0 preferred.
- Eligibility: portN is eligible when reqN_valid=1 AND (rspN_valid=0 OR rspN_ready=1). The slot is free, or it drains this same cycle.
- Grant (combinational, at most one per cycle):
  - Only one port eligible: that port wins.
  - Both eligible: the port selected by rr_ptr wins.
  - reqN_ready=1 only for the winner; a "fire" is reqN_valid & reqN_ready.
- rom_addr = winner's reqN_addr; 0 when no grant.
- rr_ptr update on each fire: rr_ptr <= the other port. No fire: rr_ptr is unchanged.
- Response capture at the clock edge ending the fire cycle (latency 1):
  - rspN_valid <= 1.
  - rspN_err <= (addr >= ROM_DEPTH).
  - rspN_data <= rom_data if in range, else 0.
- Response retire: rspN_valid & rspN_ready with no new fire on N: rspN_valid <= 0; rspN_data and rspN_err hold their last values.
- Simultaneous retire and fire on the same port: the new response replaces the old one, and rspN_valid stays 1.
- rspN_valid=1 with rspN_ready=0: port N is ineligible. Its data and err are held stable until accepted.
- Throughput:
  - One fire per cycle in total.
  - A lone requester with rspN_ready tied high completes one request every cycle.
  - Two contending requesters alternate strictly.
- Comparison: addr is compared as an unsigned 32-bit value against ROM_DEPTH.
- Combinational paths:
  - rspN_ready -> reqN_ready is combinational.
  - reqN_valid and reqN_addr -> rom_addr is combinational.
  - No path from rom_data to any *_ready.

Test Plan:
- ROM model for all scenarios: ROM_DEPTH=256, rom_data = addr ^ 32'hA5A5_0000.
- Reset/idle: hold reset=0 for 3 cycles, then release with no requests. Required: all rsp*_valid=0, req*_ready=0, rom_addr=0, rsp*_data=0.
- Single port: req0 addr=5, rsp0_ready=1. Required: req0_ready=1 in cycle N; in cycle N+1, rsp0_valid=1, rsp0_data=32'hA5A5_0005, rsp0_err=0.
- Contention: both ports valid every cycle, addrs 0x10 and 0x20, both rsp_ready=1, starting right after reset. Required: grants alternate 0,1,0,1; rom_addr alternates 0x10 and 0x20.
- Backpressure: port 0 fires addr=7 while rsp0_ready=0 for 4 cycles and req0 stays valid. Required: rsp0_data is held at 32'hA5A5_0007; req0_ready=0 and port 1 receives every grant. When rsp0_ready=1, port 0 is granted the same cycle, and the new response is valid the next cycle.
- Out of range: req1 addr=300. Required: rsp1_valid=1, rsp1_err=1, rsp1_data=0. A following request to addr=3 returns rsp1_err=0 and rsp1_data=32'hA5A5_0003.
- Reset mid-operation: rsp0_valid=1 pending, then reset=0 asserted between clock edges. Required: rsp0_valid=0 immediately (asynchronous). After release, port 0 wins the first contended grant.
